// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between the 6502 core and a
// DMA/test port. Every ownership change passes through a one-cycle TURN
// bubble in which the port is forced to read, so no write can slip through
// during a handover.
// Build macro MEM_ARB_FAIRNESS_EN: when defined, DMA may complete at most
// STARVE_MAX consecutive beats before the core is given one access.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data_out,
  input  logic              cpu_read_en,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_data_in,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_data_in
);

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    TURN    = 2'd1,
    DMA_OWN = 2'd2
  } own_e;

  own_e              state, state_nxt;
  logic              next_owner, next_owner_nxt;  // 1: DMA follows TURN
  logic              beat;
  logic              rd_beat;
  logic              fair_hit;
  logic [DATA_W-1:0] cpu_hold_p1;
  logic [DATA_W-1:0] dma_rdata_p1;
  logic              dma_rvld_p1;

  // A beat is any DMA_OWN cycle with a live request (grant equals request there).
  assign beat    = (state == DMA_OWN) && dma_req;
  assign rd_beat = beat && !dma_we;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  logic [3:0] beat_cnt;

  // Count consecutive DMA beats; any core-owned cycle restarts the count.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (state == CPU_OWN) begin
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + 4'd1;
    end
  end

  // The STARVE_MAX-th beat hands the port back to the core for one access.
  assign fair_hit = beat && (beat_cnt == STARVE_LAST);
`else
  // STARVE_MAX only matters in the fairness build.
  logic [3:0] unused_starve;
  assign unused_starve = 4'(STARVE_MAX);
  assign fair_hit      = 1'b0;
`endif

  // Ownership state register.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state      <= CPU_OWN;
      next_owner <= 1'b0;
    end else begin
      state      <= state_nxt;
      next_owner <= next_owner_nxt;
    end
  end

  // Next ownership plus the combinational memory-port steering.
  always_comb begin
    state_nxt      = state;
    next_owner_nxt = next_owner;
    cpu_ready      = 1'b0;
    dma_gnt        = 1'b0;
    mem_address    = cpu_address;
    mem_data_out   = '0;
    mem_read_en    = 1'b1;
    cpu_data_in    = cpu_hold_p1;
    unique case (state)
      CPU_OWN: begin
        cpu_ready    = 1'b1;
        cpu_data_in  = mem_data_in;
        mem_address  = cpu_address;
        mem_read_en  = cpu_read_en;
        mem_data_out = cpu_read_en ? '0 : cpu_data_out;
        if (dma_req) begin
          state_nxt      = TURN;
          next_owner_nxt = 1'b1;
        end
      end
      TURN: begin
        // Keep the outgoing owner's address on the bus while reading only.
        mem_address = next_owner ? cpu_address : dma_address;
        state_nxt   = next_owner ? DMA_OWN : CPU_OWN;
      end
      DMA_OWN: begin
        dma_gnt      = dma_req;
        mem_address  = dma_address;
        mem_read_en  = !(dma_req && dma_we);
        mem_data_out = (dma_req && dma_we) ? dma_wdata : '0;
        if (!dma_req || fair_hit) begin
          state_nxt      = TURN;
          next_owner_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt      = CPU_OWN;
        next_owner_nxt = 1'b0;
      end
    endcase
    // While reset is held the port is parked: core side ready, nothing written.
    if (reset) begin
      cpu_ready    = 1'b1;
      dma_gnt      = 1'b0;
      mem_read_en  = 1'b1;
      mem_data_out = '0;
    end
  end

  // Stage p1: registered DMA read data/valid and the core's held read data.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      dma_rvld_p1  <= 1'b0;
      dma_rdata_p1 <= '0;
      cpu_hold_p1  <= '0;
    end else begin
      dma_rvld_p1 <= rd_beat;
      if (rd_beat) begin
        dma_rdata_p1 <= mem_data_in;
      end
      if (state == CPU_OWN) begin
        cpu_hold_p1 <= mem_data_in;
      end
    end
  end

  assign dma_rdata  = dma_rdata_p1;
  assign dma_rvalid = dma_rvld_p1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed handover/reset scenarios followed by
// randomized core and DMA traffic, scored against a transaction-level model
// of port ownership and a shadow copy of memory.
module tb_mem_arbiter;

  localparam int STARVE = 4;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        ph1 = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data_out;
  logic        cpu_read_en;
  logic        cpu_ready;
  logic [7:0]  cpu_data_in;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_address;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_out;
  logic        mem_read_en;
  logic [7:0]  mem_data_in;

  always #5 ph1 = ~ph1;

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_MAX(STARVE)) dut (
    .ph1(ph1), .reset(reset),
    .cpu_address(cpu_address), .cpu_data_out(cpu_data_out), .cpu_read_en(cpu_read_en),
    .cpu_ready(cpu_ready), .cpu_data_in(cpu_data_in),
    .dma_req(dma_req), .dma_we(dma_we), .dma_address(dma_address), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_read_en(mem_read_en),
    .mem_data_in(mem_data_in)
  );

  // ---------------- memory attached to the DUT ----------------
  logic [7:0] ram    [0:65535];
  bit         ram_wr [0:65535];

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] peek(input logic [15:0] a);
    return ram_wr[a] ? ram[a] : init_byte(a);
  endfunction

  always_comb mem_data_in = ram_wr[mem_address] ? ram[mem_address] : init_byte(mem_address);

  always @(posedge ph1) begin
    if (!mem_read_en) begin
      ram[mem_address]    <= mem_data_out;
      ram_wr[mem_address] <= 1'b1;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Holder of the port: 0 core, 1 handover bubble, 2 DMA.
  logic [7:0] ref_mem [0:65535];
  int         m_own;
  int         m_after;   // holder once the bubble ends
  int         m_run;     // DMA beats since the core last held the port
  logic [7:0] m_held;    // what the core saw on its last owned cycle
  bit         m_rv_next;

  typedef struct {
    bit          ready;
    bit          gnt;
    bit          rd_en;
    bit          rvalid;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  cdin;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rdata_q[$];
  bit         mon_en = 1'b0;

  logic       obs_ready, obs_gnt, obs_rvalid;
  logic [7:0] obs_cdin, obs_rdata;

  task automatic model_reset();
    m_own = 0; m_after = 0; m_run = 0; m_held = 8'h00; m_rv_next = 1'b0;
    exp_q.delete();
    rdata_q.delete();
  endtask

  // One clock cycle: drive inputs, post expectations, advance the model.
  task automatic step(input bit req, input bit we, input logic [15:0] da, input logic [7:0] dw,
                      input logic [15:0] ca, input logic [7:0] cw, input bit crd);
    exp_t e;
    bit core, dmap, bt;
    dma_req = req; dma_we = we; dma_address = da; dma_wdata = dw;
    cpu_address = ca; cpu_data_out = cw; cpu_read_en = crd;
    core = (m_own == 0);
    dmap = (m_own == 2);
    bt   = dmap && req;
    e.ready  = core;
    e.gnt    = bt;
    e.rd_en  = core ? crd : (bt ? !we : 1'b1);
    e.addr   = core ? ca : (dmap ? da : ((m_after == 2) ? ca : da));
    e.wdata  = core ? cw : dw;
    e.cdin   = core ? ref_mem[ca] : m_held;
    e.rvalid = m_rv_next;
    exp_q.push_back(e);
    if (bt && !we) rdata_q.push_back(ref_mem[da]);
    #3;
    obs_ready = cpu_ready; obs_gnt = dma_gnt; obs_cdin = cpu_data_in;
    obs_rvalid = dma_rvalid; obs_rdata = dma_rdata;
    @(posedge ph1);
    #1;
    m_rv_next = bt && !we;
    if (core) begin
      m_held = ref_mem[ca];
      if (!crd) ref_mem[ca] = cw;
    end
    if (bt && we) ref_mem[da] = dw;
    if (core) begin
      m_run = 0;
      if (req) begin m_own = 1; m_after = 2; end
    end else if (m_own == 1) begin
      m_own = m_after;
    end else begin
      if (bt) m_run++;
      if (!req || (FAIR && m_run == STARVE)) begin m_own = 1; m_after = 0; end
    end
  endtask

  // Raise dma_req and hold it until the first grant; lat = cycles waited.
  task automatic dma_open(input bit we, input logic [15:0] a, input logic [7:0] d, output int lat);
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, we, a, d, 16'h0020, 8'h00, 1'b1);
      if (obs_gnt) return;
      lat++;
    end
  endtask

  // Drop dma_req and let the core read ca until it is ready; n = cycles waited.
  task automatic wait_ready(input logic [15:0] ca, output int n);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 16'h0000, 8'h00, ca, 8'h00, 1'b1);
      if (obs_ready) return;
      n++;
    end
  endtask

  // Monitor: compares the DUT against the oldest posted expectation each cycle.
  always @(negedge ph1) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check("exp_queue_empty", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("cpu_ready",   32'(cpu_ready),   32'(e.ready));
        check("dma_gnt",     32'(dma_gnt),     32'(e.gnt));
        check("mem_read_en", 32'(mem_read_en), 32'(e.rd_en));
        check("mem_address", 32'(mem_address), 32'(e.addr));
        check("cpu_data_in", 32'(cpu_data_in), 32'(e.cdin));
        check("dma_rvalid",  32'(dma_rvalid),  32'(e.rvalid));
        if (!e.rd_en) check("mem_data_out", 32'(mem_data_out), 32'(e.wdata));
      end
      if (dma_rvalid) begin
        if (rdata_q.size() == 0) check("rvalid_unexpected", 32'(dma_rvalid), 0);
        else check("dma_rdata", 32'(dma_rdata), 32'(rdata_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : main
    int         lat, n, rdy_cnt, gnt_cnt;
    logic [4:0] rdy_seq;
    logic [7:0] vlo, vhi;
    bit         cur_req;

    // Reset state with a core write and DMA write request pending.
    reset = 1'b1;
    dma_req = 1'b1; dma_we = 1'b1; dma_address = 16'h0030; dma_wdata = 8'hEE;
    cpu_address = 16'h0010; cpu_data_out = 8'h99; cpu_read_en = 1'b0;
    for (int i = 0; i < 65536; i++) ref_mem[16'(i)] = init_byte(16'(i));
    model_reset();
    @(posedge ph1);
    #1;
    check("rst_cpu_ready",   32'(cpu_ready),   1);
    check("rst_dma_gnt",     32'(dma_gnt),     0);
    check("rst_mem_read_en", 32'(mem_read_en), 1);
    check("rst_dma_rvalid",  32'(dma_rvalid),  0);
    check("rst_dma_rdata",   32'(dma_rdata),   0);
    @(posedge ph1);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // DMA write 0xCF to 0x0042, release, read it back.
    step(1'b0, 1'b0, 16'h0000, 8'h00, 16'h0020, 8'h00, 1'b1);
    dma_open(1'b1, 16'h0042, 8'hCF, lat);
    check("wr_gnt_latency", 32'(lat), 2);
    wait_ready(16'h0020, n);
    check("wr_release_latency", 32'(n), 2);
    dma_open(1'b0, 16'h0042, 8'h00, lat);
    check("rd_gnt_latency", 32'(lat), 2);
    step(1'b0, 1'b0, 16'h0000, 8'h00, 16'h0020, 8'h00, 1'b1);
    check("rd_rvalid_pulse", 32'(obs_rvalid), 1);
    check("rd_rdata_cf",     32'(obs_rdata),  32'h00CF);
    wait_ready(16'h0020, n);
    check("rd_release_latency", 32'(n), 1);
    check("ram_0042", 32'(peek(16'h0042)), 32'h00CF);

    // Reset in the middle of DMA ownership with a write presented.
    dma_open(1'b0, 16'h0044, 8'h00, lat);
    mon_en = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1; dma_address = 16'h0045; dma_wdata = 8'h11;
    reset = 1'b1;
    #1;
    check("midrst_cpu_ready",   32'(cpu_ready),   1);
    check("midrst_dma_gnt",     32'(dma_gnt),     0);
    check("midrst_mem_read_en", 32'(mem_read_en), 1);
    @(posedge ph1);
    #1;
    check("midrst_rvalid", 32'(dma_rvalid), 0);
    check("midrst_rdata",  32'(dma_rdata),  0);
    check("midrst_ram",    32'(peek(16'h0045)), 32'(init_byte(16'h0045)));
    reset = 1'b0;
    dma_req = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Load the reset vector by DMA, then the core fetches it.
    step(1'b0, 1'b0, 16'h0000, 8'h00, 16'h0020, 8'h00, 1'b1);
    dma_open(1'b1, 16'hFFFC, 8'h00, lat);
    check("vec_gnt_latency", 32'(lat), 2);
    step(1'b1, 1'b1, 16'hFFFD, 8'hF0, 16'h0020, 8'h00, 1'b1);
    wait_ready(16'hFFFC, n);
    check("vec_release_latency", 32'(n), 2);
    vlo = obs_cdin;
    step(1'b0, 1'b0, 16'h0000, 8'h00, 16'hFFFD, 8'h00, 1'b1);
    vhi = obs_cdin;
    check("reset_vector", {16'h0000, vhi, vlo}, 32'h0000F000);

    // Core read data stays put while DMA owns the port.
    step(1'b0, 1'b0, 16'h0000, 8'h00, 16'h0100, 8'h5A, 1'b0);
    step(1'b1, 1'b0, 16'h0005, 8'h00, 16'h0100, 8'h00, 1'b1);
    check("stall_read", 32'(obs_cdin), 32'h005A);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 16'h0005 + 16'(k), 8'h00, 16'h0007, 8'h00, 1'b1);
      check("stall_hold", 32'(obs_cdin), 32'h005A);
    end
    wait_ready(16'h0007, n);
    check("stall_release_latency", 32'(n), 2);

    // dma_req held for a long stretch.
    rdy_cnt = 0;
    for (int k = 0; k < 22; k++) begin
      step(1'b1, 1'b0, 16'(16'h0008 + 16'(k)), 8'h00, 16'h0009, 8'h00, 1'b1);
      if (k >= 2 && obs_ready) rdy_cnt++;
    end
`ifdef MEM_ARB_FAIRNESS_EN
    check("fair_core_slots", 32'(rdy_cnt), 3);
`else
    check("starve_core_slots", 32'(rdy_cnt), 0);
`endif
    wait_ready(16'h0009, n);

    // One-cycle dma_req pulse: bubble, empty DMA cycle, bubble, core.
    step(1'b0, 1'b0, 16'h0000, 8'h00, 16'h0020, 8'h00, 1'b1);
    rdy_seq = '0;
    gnt_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step(k == 0, 1'b1, 16'h0033, 8'h77, 16'h0020, 8'h00, 1'b1);
      rdy_seq = {rdy_seq[3:0], obs_ready};
      if (obs_gnt || obs_rvalid) gnt_cnt++;
    end
    check("pulse_ready_seq", 32'(rdy_seq), 32'b10001);
    check("pulse_no_grant",  32'(gnt_cnt), 0);
    check("pulse_no_write",  32'(peek(16'h0033)), 32'(init_byte(16'h0033)));

    // Randomized traffic.
    cur_req = 1'b0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 5) == 0) cur_req = !cur_req;
      step(cur_req, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 8'($urandom),
           16'($urandom_range(0, 63)), 8'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 16'h0000, 8'h00, 16'h0020, 8'h00, 1'b1);
    check("rdata_queue_drained", 32'(rdata_q.size()), 0);

    for (int i = 0; i < 64; i++) check("mem_final", 32'(peek(16'(i))), 32'(ref_mem[16'(i)]));
    check("mem_final_0100", 32'(peek(16'h0100)), 32'(ref_mem[16'h0100]));
    check("mem_final_fffc", 32'(peek(16'hFFFC)), 32'(ref_mem[16'hFFFC]));
    check("mem_final_fffd", 32'(peek(16'hFFFD)), 32'(ref_mem[16'hFFFD]));

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single memory port (ROM/RAM) between the 6502 core and a DMA/test port. Sits between `chip` and `mem` inside `top`. The DMA port loads images and reads back results while the core is held via `cpu_ready` (RDY). A three-state ownership FSM inserts a turnaround bubble on every ownership change, and an optional fairness limiter bounds core starvation.

## Interface
Parameters:
- `ADDR_W`, 16, address width
- `DATA_W`, 8, data width
- `STARVE_MAX`, 4, consecutive DMA beats before one forced core cycle (fairness build only; legal range 1–15)

Ports:
- `ph1`  in  1  clock; all flops on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cpu_address`  in  ADDR_W  core address
- `cpu_data_out`  in  DATA_W  core write data
- `cpu_read_en`  in  1  1 = core read, 0 = core write
- `cpu_ready`  out  1  core access accepted this cycle; 0 stalls core
- `cpu_data_in`  out  DATA_W  read data to core
- `dma_req`  in  1  DMA beat requested
- `dma_we`  in  1  1 = DMA write
- `dma_address`  in  ADDR_W  DMA address
- `dma_wdata`  in  DATA_W  DMA write data
- `dma_gnt`  out  1  DMA beat accepted this cycle
- `dma_rdata`  out  DATA_W  registered DMA read data
- `dma_rvalid`  out  1  one-cycle pulse, `dma_rdata` valid
- `mem_address`  out  ADDR_W  to memory
- `mem_data_out`  out  DATA_W  to memory
- `mem_read_en`  out  1  1 = read, 0 = write
- `mem_data_in`  in  DATA_W  combinational read data from memory

## Operation
- FSM states: `CPU_OWN`, `TURN`, `DMA_OWN`. A 1-bit `next_owner` register records the owner that follows `TURN`.
- `CPU_OWN`:
  - `mem_*` = `cpu_*`; `cpu_ready`=1; `cpu_data_in` = `mem_data_in`.
  - `dma_req`=1 at edge → `TURN`, `next_owner`=DMA. The core access in that cycle completes.
- `TURN`:
  - `cpu_ready`=0, `dma_gnt`=0; `mem_read_en` forced 1, so no write can occur.
  - `mem_address` = address of the last owner.
  - Next state is `next_owner`.
- `DMA_OWN`:
  - `mem_*` = `dma_*`; `dma_gnt` = `dma_req`; `cpu_ready`=0.
  - A beat is a cycle with `dma_req & dma_gnt`. A read beat captures `mem_data_in` into `dma_rdata` at the edge ending the beat.
  - `dma_req`=0 at edge → `TURN`, `next_owner`=CPU.
- `dma_req` deasserting in `TURN`, with `next_owner`=DMA: enter `DMA_OWN` anyway. No beat occurs, then the FSM returns via `TURN`.
- `cpu_data_in`:
  - Outside `CPU_OWN`, holds a register loaded with `mem_data_in` on every `CPU_OWN` edge.
  - Stable while the core is stalled.
- `dma_wdata`/`cpu_data_out` are never driven to memory while `mem_read_en`=1. `mem_data_out` follows the owner's write data.
- Reset values (held while `reset`=1):
  - FSM `CPU_OWN`, beat counter 0, `dma_rvalid` 0, `dma_rdata` 0, held `cpu_data_in` register 0.
  - `cpu_ready` 1, `dma_gnt` 0, `mem_read_en` forced 1.
- Reset mid-DMA aborts the burst. No partial write is issued during reset.

## Timing
- Core to DMA handover:
  - Request seen at edge k; `TURN` in cycle k+1; first DMA beat in cycle k+2.
  - Latency: 2 cycles from `dma_req` rising to `dma_gnt`.
- DMA to core: `dma_req` low at edge k → `cpu_ready`=1 in cycle k+2.
- DMA read: beat in cycle n → `dma_rvalid`=1 and `dma_rdata` valid in cycle n+1. Back-to-back read beats give back-to-back `rvalid` pulses.
- DMA write: committed in the beat cycle (memory writes on the edge ending it).
- `cpu_ready`, `dma_gnt`, `mem_*` are combinational from state plus inputs. No combinational path from `mem_data_in` to `dma_rdata`.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - A 4-bit counter counts consecutive DMA beats; it clears in `CPU_OWN`.
  - At the `STARVE_MAX`-th beat: → `TURN` → `CPU_OWN` for exactly one cycle (one core access).
  - Then, if `dma_req`=1: → `TURN` → `DMA_OWN`.
  - Worst-case core stall: `STARVE_MAX`+2 cycles.
- Undefined: no counter. DMA holds the port as long as `dma_req`=1; the core may starve indefinitely.

## Test plan
- Reset:
  - Assert `reset` mid-`DMA_OWN` with `dma_we`=1 → immediately `cpu_ready`=1, `dma_gnt`=0, `mem_read_en`=1.
  - Memory is unchanged at the DMA address.
- DMA write/readback:
  - Write 8'hCF to 16'h0042, release, then read 16'h0042.
  - → `dma_gnt` 2 cycles after each `dma_req` rise; `dma_rvalid` pulse with `dma_rdata`=8'hCF; RAM[66]=8'hCF.
- Core read after DMA:
  - Load ROM[16'hFFFC]=8'h00 and [16'hFFFD]=8'hF0 by DMA; release.
  - → `cpu_ready`=1 two cycles later; core fetches vector 16'hF000.
- Stall stability:
  - Core reads 8'h5A, then `dma_req` rises.
  - → `cpu_data_in` holds 8'h5A through `TURN`/`DMA_OWN` while DMA reads other data.
  - No write strobe in any `TURN` cycle.
- Fairness (macro defined, `STARVE_MAX`=4):
  - Hold `dma_req`=1 for 20 cycles.
  - → pattern of 4 beats, `TURN`, 1 `CPU_OWN`, `TURN`, repeating.
  - Macro undefined → `cpu_ready`=0 for all 20 cycles after handover.
- Request drop in `TURN`:
  - Pulse `dma_req` for 1 cycle.
  - → `TURN`, `DMA_OWN` with `dma_gnt`=0, `TURN`, `CPU_OWN`; no memory write; `dma_rvalid` stays 0.
